// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared refill-arbiter state encoding and requester identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DELIVER  = 2'd3
    } refill_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int FILL_INDEX_W = 7;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant with a single last-grant register.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_id
);

    logic r_last;
    logic w_id;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        w_id = REQ_I;
        if (req[REQ_I] && req[REQ_D]) begin
            w_id = ~r_last;
        end else if (req[REQ_D]) begin
            w_id = REQ_D;
        end
    end

    assign grant_valid = |req;
    assign grant_id    = w_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= REQ_I;
        end else if (accept && grant_valid) begin
            r_last <= w_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_arbiter
// Brief    : Arbitrates I/D cache line refills onto one memory read channel.
//            Optional watchdog enabled by CACHE_REFILL_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int LINE_WIDTH     = 512,
    parameter int ADDR_W         = 26,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic                    d_req,
    input  logic [ADDR_W-1:0]       d_addr,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [LINE_WIDTH-1:0]   mem_rsp_data,
    output logic [LINE_WIDTH-1:0]   fill_data,
    output logic [FILL_INDEX_W-1:0] fill_index,
    output logic                    i_fill_valid,
    output logic                    d_fill_valid,
    output logic                    busy,
    output logic                    err
);

    refill_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_owner;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_timeout;

    assign w_accept     = (r_state == ST_IDLE);
    assign mem_req_addr = r_addr;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         ({d_req, i_req}),
        .accept      (w_accept),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

`ifdef CACHE_REFILL_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_waiting;

    // Counter is zero on every entry to ISSUE/WAIT_RSP because any transition out clears it.
    assign w_waiting = ((r_state == ST_ISSUE) && !mem_req_ready) ||
                       ((r_state == ST_WAIT_RSP) && !mem_rsp_valid);
    assign w_timeout = w_waiting && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !w_waiting || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_owner       <= REQ_I;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b0;
            i_fill_valid  <= 1'b0;
            d_fill_valid  <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            fill_data     <= '0;
            fill_index    <= '0;
        end else begin
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_addr        <= (w_grant_id == REQ_D) ? d_addr : i_addr;
                        r_owner       <= w_grant_id;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
                        r_state       <= ST_WAIT_RSP;
                    end else if (w_timeout) begin
                        mem_req_valid <= 1'b0;
                        busy          <= 1'b0;
                        err           <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        mem_rsp_ready <= 1'b0;
                        fill_data     <= mem_rsp_data;
                        fill_index    <= r_addr[FILL_INDEX_W-1:0];
                        i_fill_valid  <= (r_owner == REQ_I);
                        d_fill_valid  <= (r_owner == REQ_D);
                        r_state       <= ST_DELIVER;
                    end else if (w_timeout) begin
                        mem_rsp_ready <= 1'b0;
                        busy          <= 1'b0;
                        err           <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_DELIVER: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_arbiter
// Brief    : Directed and randomized self-checking bench for cache_refill_arbiter
//            (timeout scenario active when CACHE_REFILL_ARB_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_arbiter;

    localparam int LW  = 512;
    localparam int AW  = 26;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req;
    logic [AW-1:0] i_addr, d_addr;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [LW-1:0] mem_rsp_data, fill_data;
    logic [6:0]    fill_index;
    logic          i_fill_valid, d_fill_valid, busy, err;

    always #5 clk = ~clk;

    cache_refill_arbiter #(
        .LINE_WIDTH     (LW),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .d_req         (d_req),
        .d_addr        (d_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .fill_data     (fill_data),
        .fill_index    (fill_index),
        .i_fill_valid  (i_fill_valid),
        .d_fill_valid  (d_fill_valid),
        .busy          (busy),
        .err           (err)
    );

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;

    // Transaction-level reference: one refill at a time, tracked as
    // granted -> request accepted -> line received -> delivered.
    bit            m_granted, m_accepted, m_deliver, m_last_d, m_owner_d, m_err;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;
    logic [6:0]    m_index;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic stall_step();
`ifdef CACHE_REFILL_ARB_TIMEOUT_EN
        m_wait++;
        if (m_wait == TMO) begin
            m_err      = 1'b1;
            m_granted  = 1'b0;
            m_accepted = 1'b0;
        end
`endif
    endtask

    task automatic tick();
        bit            s_reset, s_i, s_d, s_rdy, s_rv, s_valid;
        logic [AW-1:0] s_ia, s_da;
        logic [LW-1:0] s_rd;
        bit            exp_req, exp_rsp;
        s_reset = reset;  s_i = i_req;  s_d = d_req;  s_rdy = mem_req_ready;
        s_rv = mem_rsp_valid;  s_ia = i_addr;  s_da = d_addr;  s_rd = mem_rsp_data;
        s_valid = mem_req_valid;
        @(posedge clk);
        if (s_valid && s_rdy && !s_reset) hs_count++;
        if (s_reset) begin
            m_granted = 0; m_accepted = 0; m_deliver = 0; m_last_d = 0;
            m_err = 0; m_wait = 0; m_data = '0; m_index = '0;
        end else if (m_deliver) begin
            m_deliver = 0; m_granted = 0; m_accepted = 0;
        end else if (!m_granted) begin
            if (s_i || s_d) begin
                m_owner_d = (s_i && s_d) ? !m_last_d : s_d;
                m_last_d  = m_owner_d;
                m_addr    = m_owner_d ? s_da : s_ia;
                m_granted = 1; m_accepted = 0; m_wait = 0;
            end
        end else if (!m_accepted) begin
            if (s_rdy) begin m_accepted = 1; m_wait = 0; end
            else stall_step();
        end else begin
            if (s_rv) begin
                m_deliver = 1; m_data = s_rd; m_index = m_addr[6:0];
            end else stall_step();
        end
        #1;
        exp_req = m_granted && !m_accepted;
        exp_rsp = m_granted && m_accepted && !m_deliver;
        chk("mem_req_valid", LW'(mem_req_valid), LW'(exp_req));
        if (exp_req) chk("mem_req_addr", LW'(mem_req_addr), LW'(m_addr));
        chk("mem_rsp_ready", LW'(mem_rsp_ready), LW'(exp_rsp));
        chk("i_fill_valid", LW'(i_fill_valid), LW'(m_deliver && !m_owner_d));
        chk("d_fill_valid", LW'(d_fill_valid), LW'(m_deliver && m_owner_d));
        chk("fill_data", fill_data, m_data);
        chk("fill_index", LW'(fill_index), LW'(m_index));
        chk("busy", LW'(busy), LW'(m_granted));
        chk("err", LW'(err), LW'(m_err));
    endtask

    task automatic wait_fill(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(i_fill_valid || d_fill_valid) && n < limit);
        chk("fill_within_bound", LW'(i_fill_valid || d_fill_valid), LW'(1'b1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  n;
        int  hs0;
        bit  pi, pd;
        bit  exp_order [3];
        exp_order = '{1'b1, 1'b0, 1'b1};
        reset = 1'b1; i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        m_granted = 0; m_accepted = 0; m_deliver = 0; m_last_d = 0; m_owner_d = 0;
        m_err = 0; m_wait = 0; m_addr = '0; m_data = '0; m_index = '0;

        // Reset state
        do_reset();
        chk("reset_busy", LW'(busy), LW'(1'b0));
        chk("reset_fill_data", fill_data, LW'(0));

        // Single instruction refill, memory immediate; request cycle counts as cycle 1
        i_req = 1; i_addr = 26'h0000ABC; mem_req_ready = 1; mem_rsp_valid = 1;
        mem_rsp_data = rand_line();
        tick();
        chk("single_req_addr", LW'(mem_req_addr), LW'(26'h0000ABC));
        n = 1;
        while (!i_fill_valid && n < 20) begin tick(); n++; end
        chk("fill_latency", LW'(n + 1), LW'(4));
        chk("single_fill_index", LW'(fill_index), LW'(7'h3C));
        chk("single_i_strobe", LW'(i_fill_valid), LW'(1'b1));
        i_req = 0;
        tick();

        // Ties after reset: data, instruction, data
        do_reset();
        i_req = 1; d_req = 1; i_addr = 26'h0123456; d_addr = 26'h0ABCDEF;
        for (int k = 0; k < 3; k++) begin
            mem_rsp_data = rand_line();
            wait_fill(20, n);
            chk($sformatf("tie_order_%0d", k), LW'(d_fill_valid), LW'(exp_order[k]));
        end
        i_req = 0; d_req = 0;
        tick();

        // Memory not ready for 10 cycles: request held stable, issued once
        do_reset();
        i_req = 1; i_addr = 26'h1555555; mem_req_ready = 0; mem_rsp_valid = 0;
        tick();
        i_addr = 26'h2AAAAAA;
        hs0 = hs_count;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stall_valid", LW'(mem_req_valid), LW'(1'b1));
            chk("stall_addr", LW'(mem_req_addr), LW'(26'h1555555));
        end
        mem_req_ready = 1;
        for (int k = 0; k < 5; k++) tick();
        chk("stall_single_issue", LW'(hs_count - hs0), LW'(1));
        mem_rsp_valid = 1; mem_rsp_data = rand_line();
        wait_fill(10, n);
        i_req = 0;
        tick();

        // Reset while waiting for the response: late response dropped
        i_req = 1; i_addr = 26'h0000123; mem_req_ready = 1; mem_rsp_valid = 0;
        tick(); tick(); tick();
        chk("wait_rsp_ready", LW'(mem_rsp_ready), LW'(1'b1));
        reset = 1; i_req = 0;
        tick();
        reset = 0; mem_rsp_valid = 1; mem_rsp_data = rand_line();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("late_rsp_no_strobe", LW'(i_fill_valid || d_fill_valid), LW'(1'b0));
            chk("late_rsp_busy", LW'(busy), LW'(1'b0));
            chk("late_rsp_ready", LW'(mem_rsp_ready), LW'(1'b0));
        end
        mem_rsp_valid = 0;

`ifdef CACHE_REFILL_ARB_TIMEOUT_EN
        // Watchdog: no response for TMO cycles
        do_reset();
        i_req = 1; i_addr = 26'h0000777; mem_req_ready = 1; mem_rsp_valid = 0;
        tick(); tick();
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            chk("tmo_err_early", LW'(err), LW'(1'b0));
        end
        i_req = 0;
        tick();
        chk("tmo_err_set", LW'(err), LW'(1'b1));
        chk("tmo_idle", LW'(busy), LW'(1'b0));
        chk("tmo_no_strobe", LW'(i_fill_valid || d_fill_valid), LW'(1'b0));
        d_req = 1; d_addr = 26'h0000456; mem_rsp_valid = 1; mem_rsp_data = rand_line();
        wait_fill(10, n);
        chk("tmo_then_served", LW'(d_fill_valid), LW'(1'b1));
        d_req = 0;
        tick();
`else
        // No watchdog: waits indefinitely
        do_reset();
        i_req = 1; i_addr = 26'h0000777; mem_req_ready = 1; mem_rsp_valid = 0;
        for (int k = 0; k < 40; k++) tick();
        chk("notmo_err", LW'(err), LW'(1'b0));
        chk("notmo_busy", LW'(busy), LW'(1'b1));
        mem_rsp_valid = 1; mem_rsp_data = rand_line();
        wait_fill(5, n);
        chk("notmo_served", LW'(i_fill_valid), LW'(1'b1));
        i_req = 0;
        tick();
`endif

        // Address change after grant is ignored
        do_reset();
        d_req = 1; d_addr = 26'h1000040; mem_req_ready = 1; mem_rsp_valid = 1;
        mem_rsp_data = rand_line();
        tick();
        d_addr = 26'h2000080;
        chk("addr_hold_req", LW'(mem_req_addr), LW'(26'h1000040));
        wait_fill(10, n);
        chk("addr_hold_index", LW'(fill_index), LW'(7'h40));
        d_req = 0;
        tick();

        // Requester withdrawing before grant generates no traffic
        do_reset();
        i_req = 1; i_addr = 26'h0000321; mem_req_ready = 0; mem_rsp_valid = 0;
        tick();
        hs0 = hs_count;
        d_req = 1; d_addr = 26'h0000999;
        tick(); tick();
        d_req = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = rand_line();
        wait_fill(10, n);
        i_req = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("withdraw_traffic", LW'(hs_count - hs0), LW'(1));

        // Randomized traffic against the reference
        pi = 0; pd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!pi && $urandom_range(3) == 0) begin pi = 1; i_addr = AW'($urandom); end
            if (!pd && $urandom_range(3) == 0) begin pd = 1; d_addr = AW'($urandom); end
            i_req = pi; d_req = pd;
            mem_req_ready = 1'($urandom_range(1));
            mem_rsp_valid = ($urandom_range(2) != 0);
            mem_rsp_data  = rand_line();
            tick();
            if (m_deliver) begin
                if (m_owner_d) pd = 0; else pi = 0;
            end else if (m_granted) begin
                if (m_owner_d) d_addr = AW'($urandom); else i_addr = AW'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
